// File: rtl/exec_csr.sv
// exec_csr -- Zicsr execute stage (CSRRW/CSRRS/CSRRC and immediate forms).
//
// Takes the forwarded old CSR value from the CSR read stage, computes the new
// CSR value and the rd write-back value, and pipelines the result through an
// exec register and a cushion register. Both registers are exported every
// cycle so the read stage can forward from them; the cushion register also
// drives the CSR file write port.
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   FLUSH, STALL, MEM_WAIT      pipeline control
//   VALID, FUNCT3, RD_ADDR,
//   RS1_ADDR, RS1_DATA          decoded instruction (RS1_ADDR doubles as zimm)
//   CSR_RVALID/ADDR/RDATA       read-stage result (RVALID=0 is a hazard)
//   STALL_REQ                   combinational hazard stall request
//   FWD_EXEC_*                  exec register CSR write intent
//   FWD_CUSHION_*, CSR_W*       cushion register CSR write intent / write port
//   REG_W_*                     integer write-back from the exec register
//   EXC_ILLEGAL                 exec register illegal-instruction flag
module exec_csr (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        STALL,
  input  logic        MEM_WAIT,
  input  logic        VALID,
  input  logic [2:0]  FUNCT3,
  input  logic [4:0]  RD_ADDR,
  input  logic [4:0]  RS1_ADDR,
  input  logic [31:0] RS1_DATA,
  input  logic        CSR_RVALID,
  input  logic [11:0] CSR_ADDR,
  input  logic [31:0] CSR_RDATA,
  output logic        STALL_REQ,
  output logic        FWD_EXEC_EN,
  output logic [11:0] FWD_EXEC_ADDR,
  output logic [31:0] FWD_EXEC_DATA,
  output logic        FWD_CUSHION_EN,
  output logic [11:0] FWD_CUSHION_ADDR,
  output logic [31:0] FWD_CUSHION_DATA,
  output logic        CSR_WREN,
  output logic [11:0] CSR_WADDR,
  output logic [31:0] CSR_WDATA,
  output logic        REG_W_EN,
  output logic [4:0]  REG_W_RD,
  output logic [31:0] REG_W_DATA,
  output logic        EXC_ILLEGAL
);

  typedef struct packed {
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_data;
    logic        reg_en;
    logic [4:0]  reg_rd;
    logic [31:0] reg_data;
    logic        illegal;
  } exec_t;

  typedef struct packed {
    logic        en;
    logic [11:0] addr;
    logic [31:0] data;
  } cush_t;

  exec_t exec_q, exec_d;
  cush_t cush_q, cush_d;

  logic [31:0] src, new_val;
  logic        csr_wr, illegal, accept;

  assign STALL_REQ = VALID && !CSR_RVALID;
  assign accept    = VALID && CSR_RVALID && !STALL && !MEM_WAIT && !FLUSH;

  always_comb begin
    src     = FUNCT3[2] ? {27'b0, RS1_ADDR} : RS1_DATA;
    new_val = 32'b0;
    csr_wr  = 1'b0;
    case (FUNCT3[1:0])
      2'b01: begin new_val = src;              csr_wr = 1'b1; end
      2'b10: begin new_val = CSR_RDATA | src;  csr_wr = (RS1_ADDR != 5'd0); end
      2'b11: begin new_val = CSR_RDATA & ~src; csr_wr = (RS1_ADDR != 5'd0); end
      default: ;
    endcase
    // Writes into the 0xC00-0xFFF read-only window trap; pure reads do not.
    illegal = (FUNCT3[1:0] == 2'b00) || (csr_wr && (CSR_ADDR[11:10] == 2'b11));
  end

  // Next exec contents. Fields are zeroed whenever their enable is clear so
  // bubbles and trapped instructions never leak stale addresses or data.
  always_comb begin
    exec_d = '0;
    if (accept) begin
      if (illegal) begin
        exec_d.illegal = 1'b1;
      end else begin
        if (csr_wr) begin
          exec_d.csr_en   = 1'b1;
          exec_d.csr_addr = CSR_ADDR;
          exec_d.csr_data = new_val;
        end
        if (RD_ADDR != 5'd0) begin
          exec_d.reg_en   = 1'b1;
          exec_d.reg_rd   = RD_ADDR;
          exec_d.reg_data = CSR_RDATA;
        end
      end
    end
    cush_d.en   = exec_q.csr_en;
    cush_d.addr = exec_q.csr_addr;
    cush_d.data = exec_q.csr_data;
  end

  // FLUSH/STALL override MEM_WAIT; exec_d is already a bubble in those cases
  // because accept excludes them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      exec_q <= '0;
      cush_q <= '0;
    end else if (FLUSH || STALL || !MEM_WAIT) begin
      exec_q <= exec_d;
      cush_q <= cush_d;
    end
  end

  assign FWD_EXEC_EN      = exec_q.csr_en;
  assign FWD_EXEC_ADDR    = exec_q.csr_addr;
  assign FWD_EXEC_DATA    = exec_q.csr_data;
  assign FWD_CUSHION_EN   = cush_q.en;
  assign FWD_CUSHION_ADDR = cush_q.addr;
  assign FWD_CUSHION_DATA = cush_q.data;
  assign CSR_WREN         = cush_q.en;
  assign CSR_WADDR        = cush_q.addr;
  assign CSR_WDATA        = cush_q.data;
  assign REG_W_EN         = exec_q.reg_en;
  assign REG_W_RD         = exec_q.reg_rd;
  assign REG_W_DATA       = exec_q.reg_data;
  assign EXC_ILLEGAL      = exec_q.illegal;

endmodule
